index_derotator: RTL and testbench

INDEX_DEROTATOR -- requirements
Module: index_derotator

---
 rtl/index_derotator_pkg.sv | 18 +
 rtl/index_derotator_seq_div.sv | 57 +++++
 rtl/index_derotator.sv | 126 ++++++++++++
 tb/tb_index_derotator.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/index_derotator_pkg.sv
// Shared maze definitions: rotation encodings and controller states used by
// the forward rotator and the index derotator.
package index_derotator_pkg;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_90  = 2'd1,
        DIR_180 = 2'd2,
        DIR_270 = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/index_derotator_seq_div.sv
// Restoring divider by a constant SIZE: one quotient bit per cycle, MSB first,
// exactly IW iterations after start; done stays high until the cycle after.
module seq_div_const #(
    parameter int SIZE = 22,
    parameter int IW   = 9,
    parameter int CW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] dividend,
    output logic          done,
    output logic [IW-1:0] quotient,
    output logic [CW-1:0] remainder
);
    localparam int CNTW = $clog2(IW + 1);
    localparam logic [CW:0]      DIVISOR = (CW + 1)'(SIZE);
    localparam logic [CNTW-1:0] LAST    = CNTW'(IW);

    logic [IW-1:0]   acc;
    logic [CW:0]     rem;
    logic [CNTW-1:0] cnt;
    logic            busy;
    logic [CW:0]     trial;
    logic            ge;

    // Remainder stays below SIZE, so shifting in one bit fits in CW+1 bits.
    assign trial = {rem[CW-1:0], acc[IW-1]};
    assign ge    = (trial >= DIVISOR);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            rem  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            acc  <= dividend;
            rem  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt != LAST) begin
                rem <= ge ? (trial - DIVISOR) : trial;
                acc <= {acc[IW-2:0], ge};
                cnt <= cnt + 1'b1;
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign done      = busy && (cnt == LAST);
    assign quotient  = acc;
    assign remainder = rem[CW-1:0];

endmodule

// File: rtl/index_derotator.sv
// Recovers unrotated (x, y) from a linear cell index seen in a rotated frame,
// using a sequential divide by SIZE and a per-direction inverse mapping.
//
// state  | meaning
// IDLE   | ready for a request
// DIVIDE | divider iterating on the latched index
// DONE   | result held until the consumer takes it
module index_derotator
    import index_derotator_pkg::*;
#(
    parameter int SIZE = 22
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [$clog2(SIZE*SIZE)-1:0]    index,
    input  logic [1:0]                      direction,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(SIZE)-1:0]         x,
    output logic [$clog2(SIZE)-1:0]         y,
    output logic                            err
);
    localparam int CW = $clog2(SIZE);
    localparam int IW = $clog2(SIZE * SIZE);

    state_e        state_q, state_d;
    dir_e          dir_q;
    logic          accept;
    logic          load_res;
    logic          div_done;
    logic [IW-1:0] quot;
    logic [CW-1:0] rem;
    logic [CW-1:0] row, col;
    logic          oob;
    logic [CW-1:0] nx, ny;
    logic [CW-1:0] x_q, y_q;
    logic          err_q;

    function automatic logic [CW-1:0] flip(input logic [CW-1:0] v);
        logic [CW:0] t;
        t = (CW + 1)'(SIZE - 1) - {1'b0, v};
        return t[CW-1:0];
    endfunction

    assign accept = (state_q == IDLE) && in_valid;

    seq_div_const #(
        .SIZE (SIZE),
        .IW   (IW),
        .CW   (CW)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .dividend  (index),
        .done      (div_done),
        .quotient  (quot),
        .remainder (rem)
    );

    // A quotient of SIZE or more means the index lies past the last cell.
    assign oob = (quot >= IW'(SIZE));
    assign row = quot[CW-1:0];
    assign col = rem;

    always_comb begin
        nx = '0;
        ny = '0;
        if (!oob) begin
            case (dir_q)
                DIR_0:   begin nx = col;       ny = row;       end
                DIR_90:  begin nx = row;       ny = flip(col); end
                DIR_180: begin nx = flip(col); ny = flip(row); end
                DIR_270: begin nx = flip(row); ny = col;       end
                default: begin nx = '0;        ny = '0;        end
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        load_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = DIVIDE;
            end
            DIVIDE: begin
                if (div_done) begin
                    state_d  = DONE;
                    load_res = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) dir_q <= dir_e'(direction);
            if (load_res) begin
                x_q   <= nx;
                y_q   <= ny;
                err_q <= oob;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign x         = x_q;
    assign y         = y_q;
    assign err       = err_q;

endmodule

// File: tb/tb_index_derotator.sv
// Scoreboard bench for index_derotator at SIZE=22: directed vectors, error,
// back-pressure, mid-division reset and an exhaustive round-trip sweep.
module tb_index_derotator;
    localparam int SIZE = 22;
    localparam int CW   = 5;
    localparam int IW   = 9;
    localparam int LAT  = IW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] index;
    logic [1:0]    direction;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ex;
        int ey;
        bit eerr;
        int idx;
        int dir;
    } exp_t;

    exp_t sb[$];

    index_derotator #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .index     (index),
        .direction (direction),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int idx, input int d);
        exp_t e;
        int r, c;
        e.idx = idx;
        e.dir = d;
        e.eerr = 0;
        e.ex = 0;
        e.ey = 0;
        if (idx >= SIZE * SIZE) begin
            e.eerr = 1;
        end else begin
            r = idx / SIZE;
            c = idx % SIZE;
            case (d)
                0: begin e.ex = c;            e.ey = r;            end
                1: begin e.ex = r;            e.ey = SIZE - 1 - c; end
                2: begin e.ex = SIZE - 1 - c; e.ey = SIZE - 1 - r; end
                default: begin e.ex = SIZE - 1 - r; e.ey = c;      end
            endcase
        end
        return e;
    endfunction

    // Forward rotator: rotated-frame index of an unrotated cell.
    function automatic int fwd(input int xx, input int yy, input int d);
        int r, c;
        case (d)
            0: begin r = yy;            c = xx;            end
            1: begin r = xx;            c = SIZE - 1 - yy; end
            2: begin r = SIZE - 1 - yy; c = SIZE - 1 - xx; end
            default: begin r = SIZE - 1 - xx; c = yy;      end
        endcase
        return r * SIZE + c;
    endfunction

    task automatic send_req(input int idx, input int d, output bit ok);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (ok) begin
            index     = idx[IW-1:0];
            direction = d[1:0];
            in_valid  = 1'b1;
            sb.push_back(model(idx, d));
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(output int lat, output bit to);
        lat = 0;
        to  = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        index = 9'd5;
        direction = 2'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (x !== '0 || y !== '0) begin errors++; $display("FAIL reset_xy got %0d,%0d want 0,0", x, y); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_vectors();
        int vi[8] = '{483, 23, 45, 45, 0, 21, 462, 250};
        int vd[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int lat;
        bit to, ok;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            send_req(vi[k], vd[k], ok);
            checks++; if (!ok) begin errors++; $display("FAIL vec_accept idx %0d not accepted", vi[k]); continue; end
            wait_out(lat, to);
            e = sb.pop_front();
            checks++; if (to || lat != LAT) begin errors++; $display("FAIL vec_latency idx %0d got %0d want %0d", vi[k], lat, LAT); end
            checks++;
            if (x !== CW'(e.ex) || y !== CW'(e.ey) || err !== e.eerr) begin
                errors++;
                $display("FAIL vec_result idx %0d dir %0d got x=%0d y=%0d err=%b want x=%0d y=%0d err=%b",
                         vi[k], vd[k], x, y, err, e.ex, e.ey, e.eerr);
            end
            consume();
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL vec_release got out_valid=%b in_ready=%b want 0,1", out_valid, in_ready); end
        end
    endtask

    task automatic test_error();
        int vi[3] = '{484, 511, 500};
        int vd[3] = '{0, 2, 3};
        int lat;
        bit to, ok;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            send_req(vi[k], vd[k], ok);
            checks++; if (!ok) begin errors++; $display("FAIL err_accept idx %0d not accepted", vi[k]); continue; end
            wait_out(lat, to);
            e = sb.pop_front();
            checks++; if (to || lat != LAT) begin errors++; $display("FAIL err_latency idx %0d got %0d want %0d", vi[k], lat, LAT); end
            checks++;
            if (err !== 1'b1 || x !== '0 || y !== '0 || e.eerr != 1) begin
                errors++;
                $display("FAIL err_result idx %0d got x=%0d y=%0d err=%b want 0 0 1", vi[k], x, y, err);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to, ok;
        exp_t e;
        send_req(100, 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept not accepted"); return; end
        wait_out(lat, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout no out_valid"); return; end
        e = sb[0];
        in_valid = 1'b1;
        index = 9'd7;
        direction = 2'd0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || x !== CW'(e.ex) || y !== CW'(e.ey) || err !== e.eerr) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got ov=%b ir=%b x=%0d y=%0d err=%b want 1 0 %0d %0d %b",
                         k, out_valid, in_ready, x, y, err, e.ex, e.ey, e.eerr);
            end
        end
        in_valid = 1'b0;
        consume();
        void'(sb.pop_front());
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got ov=%b ir=%b want 0 1", out_valid, in_ready); end
        repeat (12) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_ignored_req got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat, seen;
        bit to, ok;
        exp_t e;
        send_req(200, 3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_accept not accepted"); return; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_after_reset got ir=%b ov=%b want 1 0", in_ready, out_valid); end
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rm_no_pulse got %0d valid cycles want 0", seen); end
        send_req(0, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rm_reaccept not accepted"); return; end
        wait_out(lat, to);
        e = sb.pop_front();
        checks++;
        if (to || lat != LAT || x !== CW'(e.ex) || y !== CW'(e.ey) || err !== e.eerr) begin
            errors++;
            $display("FAIL rm_next got lat=%0d x=%0d y=%0d err=%b want %0d 0 0 0", lat, x, y, err, LAT);
        end
        consume();
    endtask

    task automatic test_sweep();
        int lat;
        bit to, ok;
        exp_t e;
        for (int i = 0; i < SIZE * SIZE; i++) begin
            for (int d = 0; d < 4; d++) begin
                send_req(i, d, ok);
                checks++; if (!ok) begin errors++; $display("FAIL sweep_accept idx %0d dir %0d", i, d); return; end
                wait_out(lat, to);
                checks++; if (to) begin errors++; $display("FAIL sweep_timeout idx %0d dir %0d", i, d); return; end
                e = sb.pop_front();
                checks++;
                if (x !== CW'(e.ex) || y !== CW'(e.ey) || err !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_result idx %0d dir %0d got %0d,%0d,%b want %0d,%0d,0", i, d, x, y, err, e.ex, e.ey);
                end
                checks++;
                if (fwd(int'(x), int'(y), d) != e.idx) begin
                    errors++;
                    $display("FAIL sweep_roundtrip idx %0d dir %0d got %0d want %0d", i, d, fwd(int'(x), int'(y), d), e.idx);
                end
                consume();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        index = '0;
        direction = '0;
        test_reset();
        test_vectors();
        test_error();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d left want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
